// File: rtl/ppl_pkg.sv
// Shared encodings for the MEM-stage read-modify-write front end.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package ppl_pkg;

    // Access size encodings carried on mSize; 2'b11 behaves as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        RMW_IDLE  = 1'b0,
        RMW_WRITE = 1'b1
    } rmw_state_t;

    // Byte index of the highest lane start for a given size. In big-endian
    // order the lane shift is measured down from this position.
    function automatic logic [1:0] lane_top(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_top = 2'd3;
            SZ_HALF: lane_top = 2'd2;
            default: lane_top = 2'd0;
        endcase
    endfunction

    // Right-justified mask covering one access of the given size.
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ppl_ld_align.sv
// Lane select plus sign/zero extension of a RAM read word; also reports the lane bit offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module ppl_ld_align
    import ppl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [4:0]  lane_sh,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Locate the addressed lane, shift it down and extend it to 32 bits.
    always_comb begin
        if (BIG_ENDIAN) begin
            lane_sh = {lane_top(size) - lane_lo, 3'b000};
        end else begin
            lane_sh = {lane_lo, 3'b000};
        end
        shifted = rd_word >> lane_sh;
        case (size)
            SZ_BYTE: ld_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/ppl_mem_rmw.sv
// MEM-stage data memory front end: byte/half stores become a 2-cycle read-modify-write, loads are aligned/extended.
// Latency: loads and word stores 0 cycles; sub-word stores 2 cycles (read, then write).
// Backpressure: stall is raised during the read cycle of a sub-word store; inputs must hold while stall is high.
// Optional: PPL_MEM_MISALIGN_TRAP_EN makes misaligned accesses pulse misalign and suppresses their write/load data.
module ppl_mem_rmw
    import ppl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mAddr,
    input  logic [31:0]       mData,
    input  logic              mWriteMem,
    input  logic              mReadMem,
    input  logic [1:0]        mSize,
    input  logic              mSigned,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    output logic              dmem_we,
    input  logic [31:0]       dmem_dout,
    output logic [31:0]       ld_data,
    output logic              stall,
    output logic              misalign
);

    rmw_state_t  state_q, state_d;
    logic [31:0] merge_q, merge_d;

    logic        is_sub;
    logic        mis_act;
    logic [1:0]  lane_lo;
    logic [4:0]  lane_sh;
    logic [31:0] al_ld;
    logic [31:0] lmask;
    logic [31:0] merged;

    // Decode the access: size class, effective lane address and misalignment.
    always_comb begin
        is_sub = (mSize == SZ_BYTE) || (mSize == SZ_HALF);
        case (mSize)
            SZ_BYTE: lane_lo = mAddr[1:0];
            SZ_HALF: lane_lo = {mAddr[1], 1'b0};
            default: lane_lo = 2'b00;
        endcase
`ifdef PPL_MEM_MISALIGN_TRAP_EN
        mis_act = (mWriteMem || mReadMem) &&
                  (((mSize == SZ_HALF) && mAddr[0]) ||
                   (!is_sub && (mAddr[1:0] != 2'b00)));
`else
        // Low address bits that do not fit the size are simply dropped.
        mis_act = 1'b0;
`endif
    end

    ppl_ld_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .rd_word (dmem_dout),
        .lane_lo (lane_lo),
        .size    (mSize),
        .sgn     (mSigned),
        .lane_sh (lane_sh),
        .ld_data (al_ld)
    );

    // Splice the store lane(s) into the word captured during the read cycle.
    always_comb begin
        lmask  = lane_mask(mSize);
        merged = (merge_q & ~(lmask << lane_sh)) | ((mData & lmask) << lane_sh);
    end

    // RMW control: next state, merge capture and memory-side outputs.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        dmem_addr = mAddr;
        dmem_din  = mData;
        dmem_we   = 1'b0;
        stall     = 1'b0;
        misalign  = mis_act;
        ld_data   = (mReadMem && !mis_act) ? al_ld : 32'h0;

        case (state_q)
            RMW_IDLE: begin
                if (mWriteMem && !mis_act) begin
                    if (is_sub) begin
                        stall   = 1'b1;
                        merge_d = dmem_dout;
                        state_d = RMW_WRITE;
                    end else begin
                        dmem_we = 1'b1;
                    end
                end
            end
            RMW_WRITE: begin
                dmem_din = merged;
                dmem_we  = 1'b1;
                state_d  = RMW_IDLE;
            end
            default: state_d = RMW_IDLE;
        endcase

        // A reset cycle never writes or stalls, even mid read-modify-write.
        if (rst) begin
            dmem_we  = 1'b0;
            stall    = 1'b0;
            misalign = 1'b0;
            state_d  = RMW_IDLE;
            merge_d  = 32'h0;
        end
    end

    // State and merge registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RMW_IDLE;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_ppl_mem_rmw.sv
// Scoreboard bench for ppl_mem_rmw against a byte-addressed memory model.
// Latency: per-cycle expectations queued by the driver, checked at negedge.
// Backpressure: driver holds sub-word stores for the two cycles the model predicts.
module tb_ppl_mem_rmw;

    localparam bit BE = 1'b0;
`ifdef PPL_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mAddr, mData;
    logic        mWriteMem, mReadMem, mSigned;
    logic [1:0]  mSize;
    logic [31:0] dmem_addr, dmem_din, dmem_dout, ld_data;
    logic        dmem_we, stall, misalign;

    always #5 clk = ~clk;

    ppl_mem_rmw #(.BIG_ENDIAN(BE), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mAddr(mAddr), .mData(mData),
        .mWriteMem(mWriteMem), .mReadMem(mReadMem), .mSize(mSize), .mSigned(mSigned),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_we(dmem_we),
        .dmem_dout(dmem_dout), .ld_data(ld_data), .stall(stall), .misalign(misalign)
    );

    // Word-wide data RAM driven by the DUT.
    logic [31:0] ram [32];
    logic        ram_clr;
    assign dmem_dout = ram[dmem_addr[6:2]];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'h0;
        end else if (dmem_we) begin
            ram[dmem_addr[6:2]] <= dmem_din;
        end
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] refm [128];

    function automatic logic [31:0] word_at(input logic [6:0] a);
        logic [31:0] r;
        int w;
        w = {25'd0, a[6:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            if (BE) r[8*(3-i) +: 8] = refm[w+i];
            else    r[8*i +: 8]     = refm[w+i];
        end
        return r;
    endfunction

    function automatic void model_store(input logic [6:0] a, input logic [1:0] sz, input logic [31:0] d);
        int ea;
        if (sz == 2'b00) begin
            refm[a] = d[7:0];
        end else if (sz == 2'b01) begin
            ea = {25'd0, a[6:1], 1'b0};
            refm[ea]   = BE ? d[15:8] : d[7:0];
            refm[ea+1] = BE ? d[7:0]  : d[15:8];
        end else begin
            ea = {25'd0, a[6:2], 2'b00};
            for (int i = 0; i < 4; i++) refm[ea+i] = BE ? d[8*(3-i) +: 8] : d[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [6:0] a, input logic [1:0] sz, input logic sgn);
        logic [15:0] h;
        int ea;
        if (sz == 2'b00) begin
            return sgn ? {{24{refm[a][7]}}, refm[a]} : {24'h0, refm[a]};
        end else if (sz == 2'b01) begin
            ea = {25'd0, a[6:1], 1'b0};
            h  = BE ? {refm[ea], refm[ea+1]} : {refm[ea+1], refm[ea]};
            return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return word_at(a);
    endfunction

    function automatic bit is_mis(input logic [1:0] a, input logic [1:0] sz);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

    // Scoreboard: one expected record per active cycle.
    typedef struct packed {
        logic        stall;
        logic        we;
        logic [31:0] din;
        logic [31:0] addr;
        logic        mis;
        logic        chk_ld;
        logic [31:0] ld;
    } exp_t;

    exp_t expq[$];
    logic act = 1'b0;
    logic fin_req = 1'b0;
    logic fin_chk = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic s, input logic w, input logic [31:0] d,
                                input logic [31:0] a, input logic m,
                                input logic cl, input logic [31:0] l);
        exp_t e;
        e.stall = s; e.we = w; e.din = d; e.addr = a; e.mis = m; e.chk_ld = cl; e.ld = l;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (act) begin
            if (expq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("dmem_addr", dmem_addr, e.addr);
                if (e.we)     chk("dmem_din", dmem_din, e.din);
                if (e.chk_ld) chk("ld_data", ld_data, e.ld);
            end
        end else if (fin_req && !fin_chk) begin
            chk("sb_leftover", expq.size(), 32'd0);
            fin_chk = 1'b1;
        end else if (!rst) begin
            chk("idle_we", {31'd0, dmem_we}, 32'd0);
            chk("idle_stall", {31'd0, stall}, 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one access and queue its per-cycle expectations.
    task automatic op(input logic wr, input logic rd, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [31:0] d, input bit rst_in_write);
        bit mis;
        mAddr = a; mData = d; mWriteMem = wr; mReadMem = rd; mSize = sz; mSigned = sgn;
        act = 1'b1;
        mis = TRAP && is_mis(a[1:0], sz) && (wr || rd);
        if (wr) begin
            if (mis) begin
                expq.push_back(mk(1'b0, 1'b0, 32'h0, a, 1'b1, 1'b0, 32'h0));
                cyc();
            end else if (sz == 2'b00 || sz == 2'b01) begin
                expq.push_back(mk(1'b1, 1'b0, 32'h0, a, 1'b0, 1'b0, 32'h0));
                if (rst_in_write) begin
                    expq.push_back(mk(1'b0, 1'b0, 32'h0, a, 1'b0, 1'b0, 32'h0));
                end else begin
                    model_store(a[6:0], sz, d);
                    expq.push_back(mk(1'b0, 1'b1, word_at(a[6:0]), a, 1'b0, 1'b0, 32'h0));
                end
                cyc();
                if (rst_in_write) rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                model_store(a[6:0], sz, d);
                expq.push_back(mk(1'b0, 1'b1, word_at(a[6:0]), a, 1'b0, 1'b0, 32'h0));
                cyc();
            end
        end else if (rd) begin
            expq.push_back(mk(1'b0, 1'b0, 32'h0, a, mis, 1'b1,
                              mis ? 32'h0 : model_load(a[6:0], sz, sgn)));
            cyc();
        end else begin
            expq.push_back(mk(1'b0, 1'b0, 32'h0, a, 1'b0, 1'b0, 32'h0));
            cyc();
        end
    endtask

    task automatic idle();
        act = 1'b0;
        mWriteMem = 1'b0;
        mReadMem = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) refm[i] = 8'h0;
        rst = 1'b1; ram_clr = 1'b1;
        mAddr = 32'h21; mData = 32'hAA; mWriteMem = 1'b1; mReadMem = 1'b0;
        mSize = 2'b00; mSigned = 1'b0;
        cyc();
        // Reset cycles with a sub-word store presented: no stall, no write.
        for (int i = 0; i < 3; i++) begin
            act = 1'b1;
            expq.push_back(mk(1'b0, 1'b0, 32'h0, 32'h21, 1'b0, 1'b0, 32'h0));
            cyc();
        end
        rst = 1'b0; ram_clr = 1'b0;

        // Word store.
        op(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        idle();
        // Byte store read-modify-write then read back.
        op(1, 0, 2'b10, 0, 32'h20, 32'h11223344, 0);
        op(1, 0, 2'b00, 0, 32'h21, 32'h000000AA, 0);
        op(0, 1, 2'b10, 0, 32'h20, 32'h0, 0);
        // Signed and unsigned sub-word loads.
        op(1, 0, 2'b10, 0, 32'h30, 32'h80FF7F01, 0);
        op(0, 1, 2'b00, 1, 32'h31, 32'h0, 0);
        op(0, 1, 2'b00, 1, 32'h32, 32'h0, 0);
        op(0, 1, 2'b00, 0, 32'h33, 32'h0, 0);
        op(0, 1, 2'b01, 1, 32'h32, 32'h0, 0);
        op(0, 1, 2'b01, 0, 32'h30, 32'h0, 0);
        // Back-to-back half stores.
        op(1, 0, 2'b10, 0, 32'h40, 32'h0, 0);
        op(1, 0, 2'b01, 0, 32'h40, 32'h0000BEEF, 0);
        op(1, 0, 2'b01, 0, 32'h42, 32'h0000CAFE, 0);
        op(0, 1, 2'b10, 0, 32'h40, 32'h0, 0);
        // Reset during the write cycle leaves memory untouched.
        op(1, 0, 2'b10, 0, 32'h60, 32'h55667788, 0);
        op(1, 0, 2'b00, 0, 32'h62, 32'h00000012, 1);
        op(0, 1, 2'b10, 0, 32'h60, 32'h0, 0);
        // Misaligned half store.
        op(1, 0, 2'b10, 0, 32'h50, 32'hA5A5A5A5, 0);
        op(1, 0, 2'b01, 0, 32'h51, 32'h00001234, 0);
        op(0, 1, 2'b10, 0, 32'h50, 32'h0, 0);
        op(0, 1, 2'b10, 0, 32'h52, 32'h0, 0);
        idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            int k;
            ra = $urandom();
            k  = $urandom_range(0, 9);
            if (k == 0) begin
                idle();
            end else begin
                op(k <= 4, (k >= 4), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, $urandom(), 0);
            end
        end
        idle();

        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
